// File: rtl/seg_scan_ctrl.sv
// Four-digit 7-segment scan scheduler. Each slot blanks the anodes first, then drives one digit.
// Content is swapped only on frame boundaries and supports leading-zero suppression and blinking.
module seg_scan_ctrl #(
    parameter int unsigned SLOT_CYCLES  = 100000,
    parameter int unsigned BLANK_CYCLES = 2000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic        mclk,
    input  logic        rst,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blink_en,
    input  logic        lz_suppress,
    input  logic        load,
    output logic        load_ack,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);
    localparam int unsigned DriveCycles = SLOT_CYCLES - BLANK_CYCLES;
    localparam int unsigned CntW = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
    localparam int unsigned FcW  = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
    localparam logic [CntW-1:0] DriveLast = CntW'(DriveCycles - 1);
    localparam logic [FcW-1:0]  FcLast    = FcW'(BLINK_FRAMES - 1);

    typedef enum logic [0:0] {StBlank, StDrive} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [1:0]      slot_q;
    logic [FcW-1:0]  fc_q;
    logic            phase_q;
    logic [15:0]     digits_q;
    logic [3:0]      dp_q;
    logic [3:0]      blink_q;
    logic            lz_q;

    logic            capture;
    logic [15:0]     digits_d;
    logic [3:0]      dp_d;
    logic [3:0]      blink_d;
    logic            lz_d;
    logic [3:0]      code;
    logic            lz_blank;
    logic            blink_off;
    logic [6:0]      seg_nxt;
    logic            dp_nxt;

    function automatic logic [6:0] decode(input logic [3:0] c);
        case (c)
            4'h0:    decode = 7'b1000000;
            4'h1:    decode = 7'b1111001;
            4'h2:    decode = 7'b0100100;
            4'h3:    decode = 7'b0110000;
            4'h4:    decode = 7'b0011001;
            4'h5:    decode = 7'b0010010;
            4'h6:    decode = 7'b0000010;
            4'h7:    decode = 7'b1111000;
            4'h8:    decode = 7'b0000000;
            4'h9:    decode = 7'b0010000;
            4'hA:    decode = 7'b0001000;
            4'hB:    decode = 7'b0000011;
            4'hC:    decode = 7'b1000110;
            4'hD:    decode = 7'b0100001;
            4'hE:    decode = 7'b0000110;
            default: decode = 7'b0001110;
        endcase
    endfunction

    // Pattern is built from the post-capture shadow so a new frame shows new content from slot 0.
    always_comb begin
        capture   = frame_start && load;
        digits_d  = capture ? digits_in   : digits_q;
        dp_d      = capture ? dp_in       : dp_q;
        blink_d   = capture ? blink_en    : blink_q;
        lz_d      = capture ? lz_suppress : lz_q;
        code      = digits_d[{slot_q, 2'b00} +: 4];
        lz_blank  = 1'b0;
        unique case (slot_q)
            2'd3:    lz_blank = lz_d && (digits_d[15:12] == 4'd0);
            2'd2:    lz_blank = lz_d && (digits_d[15:8] == 8'd0);
            2'd1:    lz_blank = lz_d && (digits_d[15:4] == 12'd0);
            default: lz_blank = 1'b0;
        endcase
        blink_off = phase_q && blink_d[slot_q];
        seg_nxt   = (blink_off || lz_blank) ? 7'b1111111 : decode(code);
        dp_nxt    = blink_off ? 1'b1 : ~dp_d[slot_q];
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            state_q     <= StBlank;
            cnt_q       <= '0;
            slot_q      <= 2'd0;
            fc_q        <= '0;
            phase_q     <= 1'b0;
            digits_q    <= 16'h0000;
            dp_q        <= 4'h0;
            blink_q     <= 4'h0;
            lz_q        <= 1'b0;
            an          <= 4'b1111;
            seg         <= 7'b1111111;
            dp          <= 1'b1;
            load_ack    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            load_ack <= capture;
            if (capture) begin
                digits_q <= digits_in;
                dp_q     <= dp_in;
                blink_q  <= blink_en;
                lz_q     <= lz_suppress;
            end
            frame_start <= (state_q == StBlank) && (slot_q == 2'd0) && (cnt_q == '0);
            case (state_q)
                StBlank: begin
                    an  <= 4'b1111;
                    seg <= seg_nxt;
                    dp  <= dp_nxt;
                    if (cnt_q == BlankLast) begin
                        state_q <= StDrive;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    an <= ~(4'b0001 << slot_q);
                    if (cnt_q == DriveLast) begin
                        state_q <= StBlank;
                        cnt_q   <= '0;
                        slot_q  <= slot_q + 2'd1;
                        // Frame boundary: count the completed frame for the blink period.
                        if (slot_q == 2'd3) begin
                            if (fc_q == FcLast) begin
                                fc_q    <= '0;
                                phase_q <= ~phase_q;
                            end else begin
                                fc_q <= fc_q + 1'b1;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the display outputs.
module tb_seg_scan_ctrl;
    logic        mclk;
    logic        rst;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  blink_en;
    logic        lz_suppress;
    logic        load;
    logic        load_ack;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;

    seg_scan_ctrl #(
        .SLOT_CYCLES (8),
        .BLANK_CYCLES(2),
        .BLINK_FRAMES(2)
    ) dut (
        .mclk       (mclk),
        .rst        (rst),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .blink_en   (blink_en),
        .lz_suppress(lz_suppress),
        .load       (load),
        .load_ack   (load_ack),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_start(frame_start)
    );

    typedef struct {
        int         t;
        string      name;
        logic [4:0] m;    // {an, seg, dp, frame_start, load_ack}
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
        logic       ack;
    } exp_t;

    exp_t q[$];
    int   tick   = 0;
    int   checks = 0;
    int   errors = 0;

    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    always @(posedge mclk) tick <= tick + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got time %0t required < 200000", $time);
        $fatal(1);
    end

    // Monitor: outputs are stable at the negedge.
    always @(negedge mclk) begin
        exp_t e;
        while (q.size() > 0 && q[0].t <= tick) begin
            e = q.pop_front();
            if (e.t < tick) begin
                checks++;
                errors++;
                $display("FAIL %s missed: sampled tick %0d required tick %0d", e.name, tick, e.t);
            end else begin
                if (e.m[4]) begin
                    checks++;
                    if (an !== e.an) begin
                        errors++;
                        $display("FAIL %s an @%0d: got %b required %b", e.name, tick, an, e.an);
                    end
                end
                if (e.m[3]) begin
                    checks++;
                    if (seg !== e.seg) begin
                        errors++;
                        $display("FAIL %s seg @%0d: got %b required %b", e.name, tick, seg, e.seg);
                    end
                end
                if (e.m[2]) begin
                    checks++;
                    if (dp !== e.dp) begin
                        errors++;
                        $display("FAIL %s dp @%0d: got %b required %b", e.name, tick, dp, e.dp);
                    end
                end
                if (e.m[1]) begin
                    checks++;
                    if (frame_start !== e.fs) begin
                        errors++;
                        $display("FAIL %s frame_start @%0d: got %b required %b",
                                 e.name, tick, frame_start, e.fs);
                    end
                end
                if (e.m[0]) begin
                    checks++;
                    if (load_ack !== e.ack) begin
                        errors++;
                        $display("FAIL %s load_ack @%0d: got %b required %b",
                                 e.name, tick, load_ack, e.ack);
                    end
                end
            end
        end
    end

    // Expected anode for cycle c after reset release: 2 blank + 6 drive cycles per slot.
    function automatic logic [3:0] exp_an(input int c);
        int s;
        int p;
        s = (c % 32) / 8;
        p = c % 8;
        if (p < 2) return 4'b1111;
        return ~(4'b0001 << s);
    endfunction

    function automatic bit in_drive(input int c);
        return (c % 8) >= 2;
    endfunction

    task automatic push(input int t, input string nm, input logic [4:0] m, input logic [3:0] a,
                        input logic [6:0] s, input logic d, input logic f, input logic k);
        exp_t e;
        e.t    = t;
        e.name = nm;
        e.m    = m;
        e.an   = a;
        e.seg  = s;
        e.dp   = d;
        e.fs   = f;
        e.ack  = k;
        q.push_back(e);
    endtask

    // Returns the tick at which cycle 0 is observed.
    task automatic do_reset(output int base);
        rst         = 1'b1;
        load        = 1'b0;
        digits_in   = 16'h0000;
        dp_in       = 4'h0;
        blink_en    = 4'h0;
        lz_suppress = 1'b0;
        repeat (3) @(negedge mclk);
        rst  = 1'b0;
        base = tick + 1;
    endtask

    task automatic wait_cyc(input int base, input int c);
        while (tick < base + c) @(negedge mclk);
    endtask

    initial begin
        int         base;
        logic [6:0] seg_1234[4];
        logic [6:0] seg_lz[2][4];
        logic [15:0] lz_vec[2];
        logic [4:0] m;
        logic [6:0] s;
        int         sl;
        int         f;

        seg_1234[0] = 7'b0011001;
        seg_1234[1] = 7'b0110000;
        seg_1234[2] = 7'b0100100;
        seg_1234[3] = 7'b1111001;
        lz_vec[0]   = 16'h0050;
        seg_lz[0][0] = 7'b1000000;
        seg_lz[0][1] = 7'b0010010;
        seg_lz[0][2] = 7'b1111111;
        seg_lz[0][3] = 7'b1111111;
        lz_vec[1]   = 16'h0000;
        seg_lz[1][0] = 7'b1000000;
        seg_lz[1][1] = 7'b1111111;
        seg_lz[1][2] = 7'b1111111;
        seg_lz[1][3] = 7'b1111111;

        // 1: idle scan after reset
        do_reset(base);
        for (int c = 0; c <= 40; c++)
            push(base + c, "idle", 5'b11111, exp_an(c), 7'b1000000, 1'b1, (c % 32) == 0, 1'b0);
        wait_cyc(base, 41);

        // 2: load 1234 held from cycle 5, captured at the cycle-32 boundary
        do_reset(base);
        for (int c = 0; c < 96; c++) begin
            sl = (c % 32) / 8;
            m  = (c >= 64 && in_drive(c)) ? 5'b11111 : 5'b10011;
            push(base + c, "load1234", m, exp_an(c), seg_1234[sl], sl != 1, (c % 32) == 0,
                 c == 33);
        end
        wait_cyc(base, 5);
        digits_in = 16'h1234;
        dp_in     = 4'b0010;
        load      = 1'b1;
        wait_cyc(base, 34);
        load = 1'b0;
        wait_cyc(base, 96);

        // 3: leading-zero suppression
        for (int v = 0; v < 2; v++) begin
            do_reset(base);
            for (int c = 0; c < 64; c++) begin
                sl = (c % 32) / 8;
                m  = (c >= 32 && in_drive(c)) ? 5'b11101 : 5'b10001;
                push(base + c, v == 0 ? "lz0050" : "lz0000", m, exp_an(c), seg_lz[v][sl], 1'b1,
                     1'b0, c == 1);
            end
            wait_cyc(base, 0);
            digits_in   = lz_vec[v];
            lz_suppress = 1'b1;
            load        = 1'b1;
            wait_cyc(base, 1);
            load = 1'b0;
            wait_cyc(base, 64);
        end

        // 4: blink digit 0 with 2-frame half-period
        do_reset(base);
        for (int c = 0; c < 192; c++) begin
            f  = c / 32;
            sl = (c % 32) / 8;
            s  = (f == 2 || f == 3) ? 7'b1111111 : 7'b0000000;
            m  = (sl == 0 && in_drive(c)) ? 5'b11110 : 5'b10010;
            push(base + c, "blink", m, exp_an(c), s, 1'b1, (c % 32) == 0, 1'b0);
        end
        wait_cyc(base, 0);
        digits_in = 16'h0008;
        blink_en  = 4'b0001;
        load      = 1'b1;
        wait_cyc(base, 1);
        load = 1'b0;
        wait_cyc(base, 192);

        // 5: reset asserted during slot 1 drive
        do_reset(base);
        for (int c = 0; c < 12; c++) begin
            m = (c >= 10) ? 5'b11110 : 5'b10010;
            push(base + c, "pre_rst", m, exp_an(c), 7'b0110000, 1'b1, c == 0, 1'b0);
        end
        wait_cyc(base, 0);
        digits_in = 16'h1234;
        load      = 1'b1;
        wait_cyc(base, 1);
        load = 1'b0;
        wait_cyc(base, 12);
        rst = 1'b1;
        push(tick + 1, "mid_rst", 5'b11111, 4'b1111, 7'b1111111, 1'b1, 1'b0, 1'b0);
        @(negedge mclk);
        rst  = 1'b0;
        base = tick + 1;
        for (int c = 0; c < 10; c++)
            push(base + c, "post_rst", 5'b11111, exp_an(c), 7'b1000000, 1'b1, c == 0, 1'b0);
        wait_cyc(base, 10);

        // 6: load dropped before the next frame boundary
        do_reset(base);
        for (int c = 0; c < 64; c++) begin
            m = (c >= 32 && in_drive(c)) ? 5'b11101 : 5'b10011;
            push(base + c, "noload", m, exp_an(c), 7'b1000000, 1'b1, (c % 32) == 0, 1'b0);
        end
        wait_cyc(base, 5);
        digits_in = 16'h1234;
        dp_in     = 4'b1111;
        load      = 1'b1;
        wait_cyc(base, 20);
        load = 1'b0;
        wait_cyc(base, 64);

        repeat (2) @(negedge mclk);
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s unchecked: got no sample, required tick %0d", e.name, e.t);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Scan scheduler for the shared 4-digit 7-segment display. It time-shares the common cathode bus between four digits and drives the anodes one at a time. It inserts an all-off blanking gap before each digit switch to suppress ghosting. It also handles leading-zero suppression and per-digit blinking, and it accepts new display content from the stopwatch core through a frame-aligned load/ack handshake.

Parameters:
SLOT_CYCLES, 100000, mclk cycles per digit slot (blank + drive); 500 Hz slot rate at 50 MHz; must be > BLANK_CYCLES
BLANK_CYCLES, 2000, cycles at the start of each slot with all anodes off; must be >= 1
BLINK_FRAMES, 64, frames per blink half-period (1 frame = 4 slots)

Ports:
mclk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
digits_in  in  16  four 4-bit codes; [3:0]=digit 0 (an[0], least significant) ... [15:12]=digit 3
dp_in  in  4  decimal point request per digit, 1=on
blink_en  in  4  per-digit blink enable
lz_suppress  in  1  leading-zero suppression enable
load  in  1  request to update displayed content; held with data until load_ack
load_ack  out  1  one-cycle pulse, content captured
an  out  4  anode enables, active-low
seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point cathode, active-low
frame_start  out  1  one-cycle pulse on the first blank cycle of slot 0

Behaviour:
- Clocking and reset: one clock (mclk); reset (rst) is synchronous and active-high.
- All outputs are registered.
- On rst: an=4'b1111, seg=7'b1111111, dp=1, load_ack=0, frame_start=0. Slot index=0, state=BLANK, slot counter=0, shadow digits/dp/blink/lz=0, blink phase=0 (visible), frame counter=0.
- rst asserted mid-operation: all of the above take effect on the next edge, regardless of state. load is ignored while rst=1.
- FSM, 2 states:
  - BLANK: an=1111 for BLANK_CYCLES cycles. seg/dp are loaded with the pattern for the current slot during BLANK, so the cathodes are stable before the anode turns on. Then go to DRIVE.
  - DRIVE: an = active-low one-hot of the slot (slot0=1110, 1=1101, 2=1011, 3=0111) for SLOT_CYCLES-BLANK_CYCLES cycles. Then slot = (slot+1) mod 4, go to BLANK.
- seg/dp never change while any anode is low.
- frame_start=1 for exactly the first BLANK cycle of slot 0, including the first cycle after reset release.
- Load handshake: sampled only in the frame_start cycle.
  - If load=1 then: capture digits_in, dp_in, blink_en, lz_suppress into shadow registers, and pulse load_ack=1 on the following cycle.
  - load=0 at that cycle: no capture, no ack. The display keeps its old content.
  - Content therefore changes only on frame boundaries, so there is no tearing within a frame.
- Decode (active-low gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Leading-zero suppression (shadow lz=1):
  - Digit 3 is blanked if its code is 0.
  - Digit 2 is blanked if digits 3 and 2 are both 0.
  - Digit 1 is blanked if digits 3, 2 and 1 are all 0.
  - Digit 0 is never suppressed.
  - A suppressed digit has seg=1111111 but still shows its dp if dp is requested.
- Blink:
  - The frame counter increments at each frame_start. At BLINK_FRAMES it wraps to 0 and toggles the blink phase.
  - While phase=1 and blink_en[i]=1, digit i has seg=1111111 and dp=1. Its anode still scans; timing is unaffected.
- Simultaneous rst and load: rst wins, no ack.

Test Plan:
Bench params are SLOT_CYCLES=8, BLANK_CYCLES=2, BLINK_FRAMES=2. Cycle 0 is the first cycle after rst release.
1. Reset/idle:
   - Required an sequence: cycles 0-1 an=1111, 2-7 an=1110, 8-9 an=1111, 10-15 an=1101, 18-23 an=1011, 26-31 an=0111, repeating from cycle 32.
   - frame_start=1 at cycles 0 and 32 only.
   - seg=1000000 everywhere, dp=1.
2. Load 16'h1234 with dp_in=4'b0010 held from cycle 5:
   - load_ack=1 at cycle 33.
   - In the frame after, slot0 seg=0011001 (4); slot1 seg=0110000 (3) with dp=0; slot2 seg=0100100 (2); slot3 seg=1111001 (1).
3. Leading-zero suppression with lz_suppress=1:
   - digits 16'h0050: slots 3 and 2 give seg=1111111, slot1 seg=0010010, slot0 seg=1000000.
   - digits 16'h0000: only slot0 is lit, with seg=1000000.
4. Blink with blink_en=4'b0001, digits 16'h0008:
   - slot0 seg=0000000 in frames 0-1 and 4-5; seg=1111111 in frames 2-3.
   - Anode timing is identical in all frames.
5. rst asserted at cycle 12 (slot1 DRIVE):
   - At cycle 13: an=1111, seg=1111111, shadow cleared.
   - After release, the cycle-0 sequence restarts with slot0 BLANK and a frame_start pulse.
6. load asserted at cycle 5 and dropped at cycle 20, before the next boundary:
   - No load_ack is produced and the display is unchanged.
